// File: rtl/cpu_stack_unit.sv
// Hardware stack engine: PUSH/POP/PEEK plus two-word CALL/RET frames over a
// single-port synchronous RAM, with a command/response handshake and sticky error flags.
module cpu_stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] push_data,
    input  logic [WIDTH-1:0] call_pc,
    input  logic [WIDTH-1:0] call_bp,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] rsp_pc,
    output logic [WIDTH-1:0] rsp_bp,
    output logic [AW:0]      sp,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // WR2   | CALL second write (return pc at sp+1)
    // RD    | first read word available (POP/PEEK data, RET pc)
    // RD2   | RET second read word available (saved bp)
    // RESP  | one-cycle response pulse
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR2  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_RD2  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_PEEK = 3'd5;

    localparam logic [AW:0] SP_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW:0] SP_CALL_MAX = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0] SP_ONE      = (AW+1)'(1);
    localparam logic [AW:0] SP_TWO      = (AW+1)'(2);

    logic [2:0]       state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] pc_q;
    logic             err_q;
    logic             accept;
    logic             can_call;
    logic             can_ret;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] mem_rd;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;

    assign cmd_ready = (state == S_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign full      = (sp == SP_DEPTH);
    assign empty     = (sp == '0);
    assign can_call  = (sp <= SP_CALL_MAX);
    assign can_ret   = (sp >= SP_TWO);
    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = rsp_valid && err_q;

    // Single RAM port: the address is steered by state and the accepted opcode.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = sp[AW-1:0];
        mem_wdata = push_data;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_PUSH: mem_we = !full;
                        OP_CALL: begin
                            mem_we    = can_call;
                            mem_wdata = call_bp;
                        end
                        OP_POP, OP_PEEK, OP_RET: mem_addr = sp[AW-1:0] - AW'(1);
                        default: ;
                    endcase
                end
            end
            S_WR2: begin
                mem_we    = !reset;
                mem_addr  = sp[AW-1:0] + AW'(1);
                mem_wdata = pc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rd <= mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            sp        <= '0;
            op_q      <= '0;
            pc_q      <= '0;
            err_q     <= 1'b0;
            rsp_data  <= '0;
            rsp_pc    <= '0;
            rsp_bp    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Clear first so a same-cycle error event below overrides it.
            if (err_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= cmd_op;
                        pc_q  <= call_pc;
                        err_q <= 1'b0;
                        state <= S_RESP;
                        case (cmd_op)
                            OP_PUSH: begin
                                if (!full) begin
                                    sp <= sp + SP_ONE;
                                end else begin
                                    overflow <= 1'b1;
                                    err_q    <= 1'b1;
                                end
                            end
                            OP_POP: begin
                                if (!empty) begin
                                    sp    <= sp - SP_ONE;
                                    state <= S_RD;
                                end else begin
                                    underflow <= 1'b1;
                                    err_q     <= 1'b1;
                                end
                            end
                            OP_PEEK: begin
                                if (!empty) begin
                                    state <= S_RD;
                                end else begin
                                    underflow <= 1'b1;
                                    err_q     <= 1'b1;
                                end
                            end
                            OP_CALL: begin
                                if (can_call) begin
                                    state <= S_WR2;
                                end else begin
                                    overflow <= 1'b1;
                                    err_q    <= 1'b1;
                                end
                            end
                            OP_RET: begin
                                if (can_ret) begin
                                    sp    <= sp - SP_TWO;
                                    state <= S_RD;
                                end else begin
                                    underflow <= 1'b1;
                                    err_q     <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_WR2: begin
                    sp    <= sp + SP_TWO;
                    state <= S_RESP;
                end
                S_RD: begin
                    if (op_q == OP_RET) begin
                        rsp_pc <= mem_rd;
                        state  <= S_RD2;
                    end else begin
                        rsp_data <= mem_rd;
                        state    <= S_RESP;
                    end
                end
                S_RD2: begin
                    rsp_bp <= mem_rd;
                    state  <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_stack_unit.sv
// Self-checking bench for cpu_stack_unit: table-driven command vectors plus
// hand-written fill/drain, sticky-flag, reset-abort and held-valid sequences.
module tb_cpu_stack_unit;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = $clog2(D);

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] PUSH = 3'd1;
    localparam logic [2:0] POP  = 3'd2;
    localparam logic [2:0] CALL = 3'd3;
    localparam logic [2:0] RET  = 3'd4;
    localparam logic [2:0] PEEK = 3'd5;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  push_data, call_pc, call_bp;
    logic          rsp_valid, rsp_err;
    logic [W-1:0]  rsp_data, rsp_pc, rsp_bp;
    logic [AW:0]   sp;
    logic          full, empty, overflow, underflow, err_clr;

    cpu_stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .push_data(push_data), .call_pc(call_pc), .call_bp(call_bp),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .rsp_pc(rsp_pc), .rsp_bp(rsp_bp), .sp(sp), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] din, pc, bp;
        logic         err;
        logic [W-1:0] data, rpc, rbp;
        int           lat;
        logic [AW:0]  sp;
    } vec_t;

    typedef struct {
        logic         err;
        logic         chk_d, chk_r;
        logic [W-1:0] data, rpc, rbp;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic hold_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=response", name);
    endtask

    // Response monitor: pops the scoreboard on every rsp_valid pulse.
    always @(negedge clk) begin
        if (q.size() != 0) chk("ready_low_busy", {31'd0, cmd_ready}, 32'd0);
        if (!rsp_valid) begin
            chk("err_outside_rsp", {31'd0, rsp_err}, 32'd0);
        end else if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp actual=1 required=0");
        end else begin
            me = q.pop_front();
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, me.err});
            chk("latency", cyc - me.acc, me.lat);
            if (me.chk_d) chk("rsp_data", {16'd0, rsp_data}, {16'd0, me.data});
            if (me.chk_r) begin
                chk("rsp_pc", {16'd0, rsp_pc}, {16'd0, me.rpc});
                chk("rsp_bp", {16'd0, rsp_bp}, {16'd0, me.rbp});
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] din, input logic [W-1:0] pc,
                         input logic [W-1:0] bp, input logic err, input logic [W-1:0] data,
                         input logic [W-1:0] rpc, input logic [W-1:0] rbp, input int lat);
        exp_t e;
        int   g;
        g = 0;
        @(negedge clk);
        while (!cmd_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) begin
            fail("ready_timeout");
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        push_data = din;
        call_pc   = pc;
        call_bp   = bp;
        e.err   = err;
        e.chk_d = (op == POP || op == PEEK) && !err;
        e.chk_r = (op == RET) && !err;
        e.data  = data;
        e.rpc   = rpc;
        e.rbp   = rbp;
        e.lat   = lat;
        e.acc   = cyc;
        @(posedge clk);
        q.push_back(e);
        @(negedge clk);
        if (!hold_valid) cmd_valid = 1'b0;
        err_clr   = 1'b0;
        push_data = 16'($urandom);
        call_pc   = 16'($urandom);
        call_bp   = 16'($urandom);
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (q.size() != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (q.size() != 0) begin
            fail("rsp_timeout");
            q.delete();
        end
    endtask

    vec_t tbl[13];
    int   rv_seen;

    initial begin
        tbl[0]  = '{PUSH, 16'h1234, 16'h0,    16'h0,    1'b0, 16'h0,    16'h0,    16'h0,    1, 4'd1};
        tbl[1]  = '{PUSH, 16'hBEEF, 16'h0,    16'h0,    1'b0, 16'h0,    16'h0,    16'h0,    1, 4'd2};
        tbl[2]  = '{POP,  16'h0,    16'h0,    16'h0,    1'b0, 16'hBEEF, 16'h0,    16'h0,    2, 4'd1};
        tbl[3]  = '{POP,  16'h0,    16'h0,    16'h0,    1'b0, 16'h1234, 16'h0,    16'h0,    2, 4'd0};
        tbl[4]  = '{CALL, 16'h0,    16'h0040, 16'h0100, 1'b0, 16'h0,    16'h0,    16'h0,    2, 4'd2};
        tbl[5]  = '{PEEK, 16'h0,    16'h0,    16'h0,    1'b0, 16'h0040, 16'h0,    16'h0,    2, 4'd2};
        tbl[6]  = '{RET,  16'h0,    16'h0,    16'h0,    1'b0, 16'h0,    16'h0040, 16'h0100, 3, 4'd0};
        tbl[7]  = '{POP,  16'h0,    16'h0,    16'h0,    1'b1, 16'h0,    16'h0,    16'h0,    1, 4'd0};
        tbl[8]  = '{PUSH, 16'h5555, 16'h0,    16'h0,    1'b0, 16'h0,    16'h0,    16'h0,    1, 4'd1};
        tbl[9]  = '{RET,  16'h0,    16'h0,    16'h0,    1'b1, 16'h0,    16'h0,    16'h0,    1, 4'd1};
        tbl[10] = '{3'd7, 16'h0,    16'h0,    16'h0,    1'b0, 16'h0,    16'h0,    16'h0,    1, 4'd1};
        tbl[11] = '{NOP,  16'h0,    16'h0,    16'h0,    1'b0, 16'h0,    16'h0,    16'h0,    1, 4'd1};
        tbl[12] = '{POP,  16'h0,    16'h0,    16'h0,    1'b0, 16'h5555, 16'h0,    16'h0,    2, 4'd0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; err_clr = 1'b0;
        push_data = '0; call_pc = '0; call_bp = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_sp", {28'd0, sp}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            issue(tbl[i].op, tbl[i].din, tbl[i].pc, tbl[i].bp, tbl[i].err,
                  tbl[i].data, tbl[i].rpc, tbl[i].rbp, tbl[i].lat);
            wait_done();
            chk($sformatf("vec%0d_sp", i), {28'd0, sp}, {28'd0, tbl[i].sp});
        end
        chk("tbl_empty", {31'd0, empty}, 32'd1);
        chk("tbl_underflow", {31'd0, underflow}, 32'd1);
        chk("tbl_overflow", {31'd0, overflow}, 32'd0);

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_underflow", {31'd0, underflow}, 32'd0);

        err_clr = 1'b1;
        issue(POP, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0, 16'h0, 16'h0, 1);
        chk("set_beats_clr", {31'd0, underflow}, 32'd1);
        wait_done();
        chk("fail_pop_sp", {28'd0, sp}, 32'd0);

        for (int i = 0; i < D; i++)
            issue(PUSH, 16'(i), 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 1);
        wait_done();
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_sp", {28'd0, sp}, D);
        issue(PUSH, 16'hDEAD, 16'h0, 16'h0, 1'b1, 16'h0, 16'h0, 16'h0, 1);
        chk("overflow_set", {31'd0, overflow}, 32'd1);
        wait_done();
        chk("overflow_sp", {28'd0, sp}, D);
        issue(CALL, 16'h0, 16'h1111, 16'h2222, 1'b1, 16'h0, 16'h0, 16'h0, 1);
        wait_done();
        for (int i = D - 1; i >= 0; i--)
            issue(POP, 16'h0, 16'h0, 16'h0, 1'b0, 16'(i), 16'h0, 16'h0, 2);
        wait_done();
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_sp", {28'd0, sp}, 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_overflow", {31'd0, overflow}, 32'd0);

        // CALL at sp=DEPTH-1 must be refused: only one slot left.
        for (int i = 0; i < D - 1; i++)
            issue(PUSH, 16'h00A0 + 16'(i), 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 1);
        issue(CALL, 16'h0, 16'h3333, 16'h4444, 1'b1, 16'h0, 16'h0, 16'h0, 1);
        wait_done();
        chk("call_edge_sp", {28'd0, sp}, D - 1);
        chk("call_edge_ovf", {31'd0, overflow}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        issue(CALL, 16'h0, 16'h0077, 16'h0088, 1'b0, 16'h0, 16'h0, 16'h0, 2);
        wait_done();
        chk("call_sp", {28'd0, sp}, 32'd2);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = RET;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rv_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) rv_seen++;
            chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_sp", {28'd0, sp}, 32'd0);
        chk("post_rst_pc", {16'd0, rsp_pc}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) rv_seen++;
        end
        chk("aborted_no_rsp", rv_seen, 32'd0);

        hold_valid = 1'b1;
        issue(PUSH, 16'hA5A5, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 1);
        issue(PEEK, 16'h0, 16'h0, 16'h0, 1'b0, 16'hA5A5, 16'h0, 16'h0, 2);
        issue(CALL, 16'h0, 16'h0200, 16'h0300, 1'b0, 16'h0, 16'h0, 16'h0, 2);
        issue(3'd7, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 1);
        issue(RET, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0200, 16'h0300, 3);
        issue(NOP, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 1);
        issue(POP, 16'h0, 16'h0, 16'h0, 1'b0, 16'hA5A5, 16'h0, 16'h0, 2);
        // Park the held command on NOP so a trailing accept cannot disturb sp.
        @(negedge clk);
        cmd_op = NOP;
        cmd_valid = 1'b0;
        hold_valid = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("held_sp", {28'd0, sp}, 32'd0);
        chk("held_empty", {31'd0, empty}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
